cam_reader: RTL



---
 rtl/cam_if.sv | 33 +++
 rtl/cam_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cam_if.sv
// Bus bundle for cam_reader: write/clear port, registered read port and dump stream.
interface cam_if;
  logic       enable;
  logic       write;
  logic       clr;
  logic [4:0] addr;
  logic [7:0] data;
  logic       rd_req;
  logic [4:0] rd_idx;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       dump_start;
  logic       dump_ready;
  logic       dump_valid;
  logic [3:0] dump_idx;
  logic [7:0] dump_data;
  logic       dump_busy;
  logic       dump_done;
  logic [4:0] dump_count;

  modport master (
    output enable, write, clr, addr, data, rd_req, rd_idx, dump_start, dump_ready,
    input  rd_valid, rd_data, rd_hit, dump_valid, dump_idx, dump_data,
           dump_busy, dump_done, dump_count
  );

  modport slave (
    input  enable, write, clr, addr, data, rd_req, rd_idx, dump_start, dump_ready,
    output rd_valid, rd_data, rd_hit, dump_valid, dump_idx, dump_data,
           dump_busy, dump_done, dump_count
  );
endinterface

// File: rtl/cam_reader.sv
// Small tagged store with a 1-cycle read port and a dump engine that streams
// every valid entry in index order over a valid/ready handshake.
module cam_reader #(
  parameter int NB_MEM = 16
) (
  input logic  clk,
  input logic  rst,
  cam_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(NB_MEM);
  localparam int CNT_W  = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MEM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NB_MEM);

  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

  logic [DATA_W-1:0] mem [NB_MEM];
  logic [NB_MEM-1:0] vld;

  logic [IDX_W-1:0] wr_sel;
  logic [IDX_W-1:0] rd_sel;
  logic             unused_idx_msb;

  logic              rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic              rd_hit_p1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic [IDX_W-1:0]  dump_idx_p1;
  logic [DATA_W-1:0] dump_data_p1;

  assign wr_sel         = bus.addr[IDX_W-1:0];
  assign rd_sel         = bus.rd_idx[IDX_W-1:0];
  assign unused_idx_msb = ^{bus.addr[4], bus.rd_idx[4]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB_MEM; i++) mem[i] <= '0;
      vld <= '0;
    end else if (bus.enable) begin
      if (bus.write) begin
        mem[wr_sel] <= bus.data;
        vld[wr_sel] <= 1'b1;
      end else if (bus.clr) begin
        vld[wr_sel] <= 1'b0;
      end
    end
  end

  // Read stage p1: samples storage before this edge's write, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
      rd_hit_p1  <= 1'b0;
    end else if (bus.enable) begin
      rd_vld_p1 <= bus.rd_req;
      if (bus.rd_req) begin
        rd_hit_p1  <= vld[rd_sel];
        rd_data_p1 <= vld[rd_sel] ? mem[rd_sel] : '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dump_start) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      SCAN: begin
        if (vld[idx]) begin
          state_nxt = SEND;
          capture   = 1'b1;
        end else if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      SEND: begin
        if (bus.dump_ready) begin
          cnt_nxt = sat_inc(cnt);
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dump stage p1: the beat is frozen on entry to SEND so later writes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      dump_idx_p1  <= '0;
      dump_data_p1 <= '0;
    end else if (bus.enable) begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        dump_idx_p1  <= idx;
        dump_data_p1 <= mem[idx];
      end
    end
  end

  assign bus.rd_valid   = rd_vld_p1;
  assign bus.rd_data    = rd_data_p1;
  assign bus.rd_hit     = rd_hit_p1;
  assign bus.dump_valid = (state == SEND);
  assign bus.dump_idx   = dump_idx_p1;
  assign bus.dump_data  = dump_data_p1;
  assign bus.dump_busy  = (state != IDLE);
  assign bus.dump_done  = (state == DONE);
  assign bus.dump_count = cnt;
endmodule
